// File: rtl/mouse_event_if.sv
// rtl/mouse_event_if.sv - board event handshake bundle between mouse_event_ctl and its consumer
//   event_valid : event available (producer)
//   event_ready : consumer accepts the event
//   event_type  : 0 = LEFT, 1 = RIGHT, 2 = HOLD
//   event_col   : board column index
//   event_row   : board row index
interface mouse_event_if #(
    parameter int COL_W = 3,
    parameter int ROW_W = 3
);
    logic             event_valid;
    logic             event_ready;
    logic [1:0]       event_type;
    logic [COL_W-1:0] event_col;
    logic [ROW_W-1:0] event_row;

    modport master (
        output event_valid,
        output event_type,
        output event_col,
        output event_row,
        input  event_ready
    );

    modport slave (
        input  event_valid,
        input  event_type,
        input  event_col,
        input  event_row,
        output event_ready
    );
endinterface

// File: rtl/mouse_event_ctl.sv
// rtl/mouse_event_ctl.sv - debounced mouse clicks turned into board cell events
// Optional feature macro: MOUSE_HOLD_EN (left long-press produces HOLD events).
// Ports:
//   clk, rst          : clock, synchronous active-low reset
//   left, right       : raw mouse buttons
//   mouse_xpos/ypos   : cursor position, captured when a click qualifies
//   ev (master)       : event_valid/event_ready handshake with type/col/row
//   off_board         : one-cycle pulse for a click outside the board
//   event_drop        : sticky, a click was lost
//   busy              : FSM not IDLE
module mouse_event_ctl #(
    parameter logic [11:0] BOARD_X         = 12'd100,
    parameter logic [11:0] BOARD_Y         = 12'd50,
    parameter int          CELL_SIZE       = 32,
    parameter int          COLS            = 8,
    parameter int          ROWS            = 8,
    parameter int          DEBOUNCE_CYCLES = 4,
    parameter int          HOLD_CYCLES     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          left,
    input  logic          right,
    input  logic [11:0]   mouse_xpos,
    input  logic [11:0]   mouse_ypos,
    mouse_event_if.master ev,
    output logic          off_board,
    output logic          event_drop,
    output logic          busy
);
    localparam int          COL_W = $clog2(COLS);
    localparam int          ROW_W = $clog2(ROWS);
    localparam int          DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [31:0] X_END = 32'(BOARD_X) + 32'(COLS * CELL_SIZE);
    localparam logic [31:0] Y_END = 32'(BOARD_Y) + 32'(ROWS * CELL_SIZE);
    localparam logic [1:0]  EV_LEFT  = 2'd0;
    localparam logic [1:0]  EV_RIGHT = 2'd1;
`ifdef MOUSE_HOLD_EN
    localparam logic [1:0]  EV_HOLD  = 2'd2;
    localparam int          HC_W     = $clog2(HOLD_CYCLES + 1);
`endif

    if (CELL_SIZE < 1 || DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_param_check
        $error("mouse_event_ctl: CELL_SIZE, DEBOUNCE_CYCLES and HOLD_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        EMIT
`ifdef MOUSE_HOLD_EN
        , HOLD_WAIT
`endif
    } state_t;

    state_t state, state_n;

    // Button index 0 = left, 1 = right.
    logic [1:0]      raw, filt, armed, rise;
    logic [DB_W-1:0] db_cnt [2];

    logic [11:0]      x_cap, y_cap, rx, ry;
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic [1:0]       type_q, type_n;
    logic             capture, drop_set, off_now, col_done, row_done;
`ifdef MOUSE_HOLD_EN
    logic [HC_W-1:0]  hold_cnt;
`endif

    assign raw = {right, left};

    // Debounce; armed stays low until the button has been seen released, so a
    // button held through reset cannot produce a click when its filter settles.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                filt[i]   <= 1'b0;
                armed[i]  <= 1'b0;
                db_cnt[i] <= '0;
            end else begin
                armed[i] <= armed[i] | (~raw[i] & ~filt[i]);
                if (raw[i] == filt[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    filt[i]   <= raw[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        rise = '0;
        for (int i = 0; i < 2; i++) begin
            rise[i] = raw[i] & ~filt[i] & armed[i] & (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1));
        end
    end

    assign off_now  = ({20'd0, x_cap} < 32'(BOARD_X)) || ({20'd0, x_cap} >= X_END) ||
                      ({20'd0, y_cap} < 32'(BOARD_Y)) || ({20'd0, y_cap} >= Y_END);
    assign col_done = {20'd0, rx} < 32'(CELL_SIZE);
    assign row_done = {20'd0, ry} < 32'(CELL_SIZE);

    always_comb begin
        state_n   = state;
        type_n    = type_q;
        capture   = 1'b0;
        drop_set  = 1'b0;
        off_board = 1'b0;
        case (state)
            IDLE: begin
                capture  = |rise;
                drop_set = rise[0] & rise[1];
                if (rise[0]) begin
`ifdef MOUSE_HOLD_EN
                    state_n = HOLD_WAIT;
`else
                    state_n = CALC;
                    type_n  = EV_LEFT;
`endif
                end else if (rise[1]) begin
                    state_n = CALC;
                    type_n  = EV_RIGHT;
                end
            end
`ifdef MOUSE_HOLD_EN
            HOLD_WAIT: begin
                drop_set = |rise;
                if (!filt[0]) begin
                    state_n = CALC;
                    type_n  = EV_LEFT;
                end else if (hold_cnt == HC_W'(HOLD_CYCLES - 1)) begin
                    state_n = CALC;
                    type_n  = EV_HOLD;
                end
            end
`endif
            CALC: begin
                drop_set = |rise;
                if (off_now) begin
                    off_board = 1'b1;
                    state_n   = IDLE;
                end else if (col_done && row_done) begin
                    state_n = EMIT;
                end
            end
            EMIT: begin
                drop_set = |rise;
                if (ev.event_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            type_q     <= EV_LEFT;
            event_drop <= 1'b0;
            x_cap      <= '0;
            y_cap      <= '0;
            rx         <= '0;
            ry         <= '0;
            col_q      <= '0;
            row_q      <= '0;
`ifdef MOUSE_HOLD_EN
            hold_cnt   <= '0;
`endif
        end else begin
            state  <= state_n;
            type_q <= type_n;
            if (drop_set) begin
                event_drop <= 1'b1;
            end
            if (capture) begin
                x_cap <= mouse_xpos;
                y_cap <= mouse_ypos;
                // Offsets wrap for off-board clicks; CALC discards them.
                rx    <= mouse_xpos - BOARD_X;
                ry    <= mouse_ypos - BOARD_Y;
                col_q <= '0;
                row_q <= '0;
            end else if (state == CALC && !off_now) begin
                if (!col_done) begin
                    rx    <= rx - 12'(CELL_SIZE);
                    col_q <= col_q + 1'b1;
                end
                if (!row_done) begin
                    ry    <= ry - 12'(CELL_SIZE);
                    row_q <= row_q + 1'b1;
                end
            end
`ifdef MOUSE_HOLD_EN
            if (state == HOLD_WAIT) begin
                hold_cnt <= hold_cnt + 1'b1;
            end else begin
                hold_cnt <= '0;
            end
`endif
        end
    end

    assign busy           = (state != IDLE);
    assign ev.event_valid = (state == EMIT);
    assign ev.event_type  = type_q;
    assign ev.event_col   = col_q;
    assign ev.event_row   = row_q;
endmodule

// File: tb/tb_mouse_event_ctl.sv
// tb/tb_mouse_event_ctl.sv - self-checking bench for mouse_event_ctl
module tb_mouse_event_ctl;
    localparam int DEB = 4;
    localparam int BX  = 100;
    localparam int BY  = 50;
    localparam int CS  = 32;
    localparam int NC  = 8;
    localparam int NR  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        left_b = 1'b0;
    logic        right_b = 1'b0;
    logic [11:0] mouse_x = '0;
    logic [11:0] mouse_y = '0;
    logic        off_board, event_drop, busy;

    int checks = 0;
    int errors = 0;

    mouse_event_if #(.COL_W(3), .ROW_W(3)) ev_if ();

    mouse_event_ctl dut (
        .clk        (clk),
        .rst        (rst),
        .left       (left_b),
        .right      (right_b),
        .mouse_xpos (mouse_x),
        .mouse_ypos (mouse_y),
        .ev         (ev_if),
        .off_board  (off_board),
        .event_drop (event_drop),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference: cell from plain division, valid at T + max(col,row) + 2 where
    // T = DEB-1 cycles after the press cycle.
    function automatic void ref_click(input int x, input int y, output bit off,
                                      output int col, output int row, output int vcyc);
        off  = (x < BX) || (x >= BX + NC * CS) || (y < BY) || (y >= BY + NR * CS);
        col  = off ? 0 : (x - BX) / CS;
        row  = off ? 0 : (y - BY) / CS;
        vcyc = (DEB - 1) + ((col > row) ? col : row) + 2;
    endfunction

    // Press at cycle 0, observe 70 cycles; outputs are observations only.
    task automatic run_click(input logic [1:0] btn, input int x, input int y,
                             input int ready_lat, input int hold_len,
                             input int extra_at, input logic [1:0] extra_btn,
                             output int off_cyc, output int off_cnt, output int valid_cyc,
                             output int n_ev, output int n_hs, output int late,
                             output int unstable, output int ev_type,
                             output int ev_col, output int ev_row);
        logic vprev;
        off_cyc = -1; off_cnt = 0; valid_cyc = -1; n_ev = 0; n_hs = 0;
        late = 0; unstable = 0; ev_type = -1; ev_col = -1; ev_row = -1;
        vprev = 1'b0;
        @(negedge clk);
        mouse_x = 12'(x);
        mouse_y = 12'(y);
        left_b  = btn[0];
        right_b = btn[1];
        ev_if.event_ready = 1'b0;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            if (off_board) begin
                off_cnt++;
                if (off_cyc < 0) off_cyc = c;
            end
            if (ev_if.event_ready && vprev) begin
                n_hs++;
                ev_if.event_ready = 1'b0;
                if (ev_if.event_valid) late++;
            end
            if (ev_if.event_valid && !vprev) begin
                n_ev++;
                if (valid_cyc < 0) begin
                    valid_cyc = c;
                    ev_type = int'(ev_if.event_type);
                    ev_col  = int'(ev_if.event_col);
                    ev_row  = int'(ev_if.event_row);
                end
            end else if (ev_if.event_valid &&
                         (int'(ev_if.event_type) != ev_type || int'(ev_if.event_col) != ev_col ||
                          int'(ev_if.event_row) != ev_row)) begin
                unstable++;
            end
            if (ev_if.event_valid && !ev_if.event_ready && c >= valid_cyc + ready_lat)
                ev_if.event_ready = 1'b1;
            vprev = ev_if.event_valid;
            if (c == extra_at) begin
                left_b  = left_b | extra_btn[0];
                right_b = right_b | extra_btn[1];
            end
            if (c == hold_len) begin
                left_b  = 1'b0;
                right_b = 1'b0;
            end
        end
        ev_if.event_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        left_b = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (ev_if.event_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ev_if.event_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (off_board !== 1'b0) begin errors++; $display("FAIL reset_off got %b want 0", off_board); end
        checks++; if (event_drop !== 1'b0) begin errors++; $display("FAIL reset_drop got %b want 0", event_drop); end
        checks++; if (ev_if.event_type !== 2'd0) begin errors++; $display("FAIL reset_type got %0d want 0", ev_if.event_type); end
        checks++; if (ev_if.event_col !== 3'd0 || ev_if.event_row !== 3'd0) begin
            errors++; $display("FAIL reset_cell got %0d,%0d want 0,0", ev_if.event_col, ev_if.event_row); end
        left_b = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_left_basic;
        int oc, on, vc, ne, nh, lt, us, ty, co, ro;
        run_click(2'b01, 170, 120, 0, 20, -1, 2'b00, oc, on, vc, ne, nh, lt, us, ty, co, ro);
        checks++; if (vc !== DEB - 1 + 4) begin errors++; $display("FAIL left_latency got %0d want %0d", vc, DEB + 3); end
        checks++; if (ty !== 0) begin errors++; $display("FAIL left_type got %0d want 0", ty); end
        checks++; if (co !== 2 || ro !== 2) begin errors++; $display("FAIL left_cell got %0d,%0d want 2,2", co, ro); end
        checks++; if (ne !== 1 || nh !== 1) begin errors++; $display("FAIL left_count got ev %0d hs %0d want 1 1", ne, nh); end
        checks++; if (lt !== 0) begin errors++; $display("FAIL left_valid_fall got %0d late want 0", lt); end
        checks++; if (on !== 0) begin errors++; $display("FAIL left_off got %0d want 0", on); end
    endtask

    task automatic test_bounce;
        int viol;
        viol = 0;
        mouse_x = 12'd170;
        mouse_y = 12'd120;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (busy || ev_if.event_valid || off_board) viol++;
            left_b = ((c / 2) % 2) == 0;
        end
        left_b = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (busy || ev_if.event_valid || off_board) viol++;
        end
        checks++; if (viol !== 0) begin errors++; $display("FAIL bounce_activity got %0d want 0", viol); end
    endtask

    task automatic test_off_board;
        int oc, on, vc, ne, nh, lt, us, ty, co, ro;
        run_click(2'b10, 99, 60, 0, 10, -1, 2'b00, oc, on, vc, ne, nh, lt, us, ty, co, ro);
        checks++; if (oc !== DEB) begin errors++; $display("FAIL off_cycle got %0d want %0d", oc, DEB); end
        checks++; if (on !== 1) begin errors++; $display("FAIL off_pulses got %0d want 1", on); end
        checks++; if (ne !== 0) begin errors++; $display("FAIL off_events got %0d want 0", ne); end
    endtask

    task automatic test_random;
        int oc, on, vc, ne, nh, lt, us, ty, co, ro;
        int x, y, rl, ecol, erow, evc, etype;
        bit eoff;
        logic [1:0] btn;
        for (int i = 0; i < 14; i++) begin
            x  = int'($urandom_range(60, 400));
            y  = int'($urandom_range(20, 350));
            rl = int'($urandom_range(0, 5));
`ifdef MOUSE_HOLD_EN
            btn = 2'b10;
`else
            btn = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
`endif
            etype = btn[1] ? 1 : 0;
            ref_click(x, y, eoff, ecol, erow, evc);
            run_click(btn, x, y, rl, 20, -1, 2'b00, oc, on, vc, ne, nh, lt, us, ty, co, ro);
            if (eoff) begin
                checks++; if (oc !== DEB || on !== 1) begin errors++; $display("FAIL rnd_off x=%0d y=%0d got cyc %0d n %0d want %0d 1", x, y, oc, on, DEB); end
                checks++; if (ne !== 0) begin errors++; $display("FAIL rnd_off_event x=%0d y=%0d got %0d want 0", x, y, ne); end
            end else begin
                checks++; if (vc !== evc) begin errors++; $display("FAIL rnd_latency x=%0d y=%0d got %0d want %0d", x, y, vc, evc); end
                checks++; if (co !== ecol || ro !== erow) begin errors++; $display("FAIL rnd_cell x=%0d y=%0d got %0d,%0d want %0d,%0d", x, y, co, ro, ecol, erow); end
                checks++; if (ty !== etype) begin errors++; $display("FAIL rnd_type got %0d want %0d", ty, etype); end
                checks++; if (ne !== 1 || nh !== 1 || lt !== 0 || us !== 0 || on !== 0) begin
                    errors++; $display("FAIL rnd_handshake got ev %0d hs %0d late %0d unstable %0d off %0d want 1 1 0 0 0", ne, nh, lt, us, on); end
            end
        end
        checks++; if (event_drop !== 1'b0) begin errors++; $display("FAIL rnd_drop got %b want 0", event_drop); end
    endtask

    task automatic test_stall_drop;
        int oc, on, vc, ne, nh, lt, us, ty, co, ro, etype;
        logic [1:0] first, second;
`ifdef MOUSE_HOLD_EN
        first = 2'b10; second = 2'b01; etype = 1;
`else
        first = 2'b01; second = 2'b10; etype = 0;
`endif
        run_click(first, 355, 305, 10, 30, DEB + 1 + 7 + 2, second, oc, on, vc, ne, nh, lt, us, ty, co, ro);
        checks++; if (vc !== DEB + 1 + 7) begin errors++; $display("FAIL stall_latency got %0d want %0d", vc, DEB + 8); end
        checks++; if (co !== 7 || ro !== 7 || ty !== etype) begin errors++; $display("FAIL stall_event got %0d,%0d t%0d want 7,7 t%0d", co, ro, ty, etype); end
        checks++; if (us !== 0) begin errors++; $display("FAIL stall_stable got %0d changes want 0", us); end
        checks++; if (event_drop !== 1'b1) begin errors++; $display("FAIL stall_drop got %b want 1", event_drop); end
        checks++; if (ne !== 1 || nh !== 1) begin errors++; $display("FAIL stall_count got ev %0d hs %0d want 1 1", ne, nh); end
    endtask

    task automatic test_reset_calc;
        int cnt;
        cnt = 0;
        @(negedge clk);
        mouse_x = 12'd355;
        mouse_y = 12'd305;
        right_b = 1'b1;
        repeat (DEB + 2) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rcalc_busy_before got %b want 1", busy); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || ev_if.event_valid !== 1'b0) begin
            errors++; $display("FAIL rcalc_after got busy %b valid %b want 0 0", busy, ev_if.event_valid); end
        checks++; if (event_drop !== 1'b0) begin errors++; $display("FAIL rcalc_drop got %b want 0", event_drop); end
        rst = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (ev_if.event_valid || busy || off_board) cnt++;
            if (c == 10) right_b = 1'b0;
        end
        checks++; if (cnt !== 0) begin errors++; $display("FAIL rcalc_no_event got %0d active cycles want 0", cnt); end
    endtask

    task automatic test_simultaneous;
        int oc, on, vc, ne, nh, lt, us, ty, co, ro;
        run_click(2'b11, 170, 120, 0, 10, -1, 2'b00, oc, on, vc, ne, nh, lt, us, ty, co, ro);
        checks++; if (ty !== 0 || ne !== 1) begin errors++; $display("FAIL simul_event got t%0d n%0d want t0 n1", ty, ne); end
        checks++; if (co !== 2 || ro !== 2) begin errors++; $display("FAIL simul_cell got %0d,%0d want 2,2", co, ro); end
        checks++; if (event_drop !== 1'b1) begin errors++; $display("FAIL simul_drop got %b want 1", event_drop); end
    endtask

`ifdef MOUSE_HOLD_EN
    task automatic test_hold;
        int oc, on, vc, ne, nh, lt, us, ty, co, ro;
        run_click(2'b01, 140, 60, 0, 30, -1, 2'b00, oc, on, vc, ne, nh, lt, us, ty, co, ro);
        checks++; if (ty !== 2 || ne !== 1) begin errors++; $display("FAIL hold_long got t%0d n%0d want t2 n1", ty, ne); end
        checks++; if (co !== 1 || ro !== 0) begin errors++; $display("FAIL hold_cell got %0d,%0d want 1,0", co, ro); end
        run_click(2'b01, 140, 60, 0, 5, -1, 2'b00, oc, on, vc, ne, nh, lt, us, ty, co, ro);
        checks++; if (ty !== 0 || ne !== 1) begin errors++; $display("FAIL hold_short got t%0d n%0d want t0 n1", ty, ne); end
        checks++; if (vc < 5 + DEB) begin errors++; $display("FAIL hold_short_timing got %0d want >= %0d", vc, 5 + DEB); end
    endtask
`endif

    initial begin
        ev_if.event_ready = 1'b0;
        test_reset();
`ifndef MOUSE_HOLD_EN
        test_left_basic();
`endif
        test_bounce();
        test_off_board();
        test_random();
        test_stall_drop();
        test_reset_calc();
        test_simultaneous();
`ifdef MOUSE_HOLD_EN
        test_hold();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mouse_event_ctl.md
MOUSE_EVENT_CTL -- requirements
Module: mouse_event_ctl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- BOARD_X, 12'd100: board left edge, in pixels.
- BOARD_Y, 12'd50: board top edge, in pixels.
- CELL_SIZE, 32: cell edge, in pixels; must be at least 1.
- COLS, 8: board columns, 2..32.
- ROWS, 8: board rows, 2..32.
- DEBOUNCE_CYCLES, 4: stable-level cycles needed before a button level is accepted; must be at least 1.
- HOLD_CYCLES, 16: left-button long-press threshold.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1: the single clock.
- rst, in, 1: synchronous, active-low reset.
- left, in, 1: raw left button from the mouse controller.
- right, in, 1: raw right button from the mouse controller.
- mouse_xpos, in, 12: cursor x position.
- mouse_ypos, in, 12: cursor y position.
- event_ready, in, 1: consumer accepts the event.
- event_valid, out, 1: event available.
- event_type, out, 2: 0 = LEFT, 1 = RIGHT, 2 = HOLD.
- event_col, out, $clog2(COLS): column index.
- event_row, out, $clog2(ROWS): row index.
- off_board, out, 1: one-cycle pulse when a click lands outside the board.
- event_drop, out, 1: sticky flag, set when a click is lost.
- busy, out, 1: FSM is not IDLE.

Function
REQ-003 Debounce, per button:
- The filtered level takes the raw value only after the raw value has differed from the filtered level for DEBOUNCE_CYCLES consecutive cycles.
- Any raw value matching the filtered level restarts that count.

REQ-004 A click is qualified in the cycle the filtered level rises.
- mouse_xpos and mouse_ypos are captured in that same cycle, called T.

REQ-005 FSM states: IDLE, CALC, EMIT. Transitions:
- IDLE to CALC on a qualified click.
- CALC to EMIT when both indices are resolved.
- CALC to IDLE when the click is off-board.
- EMIT to IDLE on handshake, i.e. event_valid and event_ready both high.

REQ-006 Off-board test, done in the first CALC cycle:
- A click is off-board if x < BOARD_X, or x >= BOARD_X + COLS*CELL_SIZE, or the equivalent condition holds for y with ROWS.
- An off-board click pulses off_board for one cycle at T+1, returns the FSM to IDLE and produces no event.

REQ-007 Index computation:
- col = (x - BOARD_X) / CELL_SIZE and row = (y - BOARD_Y) / CELL_SIZE.
- Each is computed by iterative subtraction at one subtraction per cycle, col and row in parallel.
- No divider and no multiplier by a variable.

REQ-008 Latency and output stability:
- event_valid rises at exactly T + max(col,row) + 2.
- event_type, event_col and event_row hold stable while event_valid is high and not yet accepted.

REQ-009 Handshake:
- event_valid falls in the cycle after the handshake.
- Back-to-back events are separated by at least one IDLE cycle.

REQ-010 Clicks arriving while busy is high are discarded and set event_drop.
- event_drop is cleared only by reset.

REQ-011 Simultaneous left and right qualification in the same cycle:
- LEFT is processed.
- RIGHT is discarded and sets event_drop.

REQ-012 The RIGHT event type is issued on the filtered right-button rising edge.

Reset
REQ-013 While rst is 0 at a clk edge, the block resets as follows:
- The FSM goes to IDLE.
- All counters and filtered levels go to 0.
- event_valid, off_board, event_drop and busy go to 0.
- event_type, event_col and event_row go to 0.

REQ-014 Reset asserted during CALC or EMIT abandons the pending event with no handshake.
- A button still held after reset is released emits nothing until the filtered level has fallen and then risen again.

Configuration
REQ-015 Macro MOUSE_HOLD_EN, when defined, enables long-press handling:
- On a left qualification, the FSM waits in IDLE-side hold tracking and counts cycles while filtered left stays high.
- If the count reaches HOLD_CYCLES, a HOLD event is issued at that moment, using the position captured at the press.
- If the button is released earlier, a LEFT event is issued at the release, using the position captured at the press.
- A release after a HOLD event emits nothing.

REQ-016 Without MOUSE_HOLD_EN:
- LEFT is issued on the filtered left-button rising edge.
- HOLD is never produced and no hold counter is synthesised.

Verification
REQ-017 Use the default parameters for all scenarios.
- Left held steadily with x=170, y=120, no MOUSE_HOLD_EN -> event_valid at T+4 with type 0, col 2, row 2.
- Left toggled every 2 cycles for 20 cycles -> no qualification, busy stays 0, no event.
- Right click at x=99, y=60 -> off_board pulses at T+1, no event_valid.
- Click at x=355, y=305 with event_ready held low for 10 cycles, then a second right click -> first event stays col 7, row 7, stable; event_drop goes to 1; after ready, exactly one handshake.
- With MOUSE_HOLD_EN: left held 30 cycles at x=140, y=60 -> one HOLD event with col 1, row 0. Left held 5 cycles -> one LEFT event at release.
- rst driven to 0 during CALC -> next cycle busy=0 and event_valid=0; no event after rst returns to 1.
